// File: rtl/polygon_edge_sequencer.sv
// polygon_edge_sequencer
//   Latches up to MAX_VERTS vertices, finds the bounding-box minimum, then
//   hands each edge (normalised to that minimum) to the line-draw engine
//   through a draw_en/draw_done handshake. Supports open polylines and
//   closed polygons.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             request (sampled only in IDLE)
//   vert_count        number of valid vertices (sampled with start)
//   closed            add closing edge last->vertex 0 (sampled with start)
//   coordinates       packed vertices: x_k at [2*COORD_W*k +: COORD_W],
//                     y_k directly above it
//   draw_done         line engine finished the current edge
//   reset_buff        one-cycle buffer clear before the first edge
//   x0, y0, x1, y1    normalised edge endpoints (zero outside DRAW)
//   draw_en           edge valid / draw request
//   seq_done          one-cycle pulse after the last edge completes
//   error             one-cycle pulse on an invalid vert_count
//   busy              high in every state except IDLE
module polygon_edge_sequencer #(
    parameter int COORD_W   = 8,
    parameter int MAX_VERTS = 4,
    parameter int CNT_W     = $clog2(MAX_VERTS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CNT_W-1:0]               vert_count,
    input  logic                           closed,
    input  logic [2*COORD_W*MAX_VERTS-1:0] coordinates,
    input  logic                           draw_done,
    output logic                           reset_buff,
    output logic [COORD_W-1:0]             x0,
    output logic [COORD_W-1:0]             y0,
    output logic [COORD_W-1:0]             x1,
    output logic [COORD_W-1:0]             y1,
    output logic                           draw_en,
    output logic                           seq_done,
    output logic                           error,
    output logic                           busy
);
    localparam int VW = 2 * COORD_W * MAX_VERTS;

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MIN, S_CLEAR, S_DRAW, S_GAP, S_DONE
    } state_t;

    state_t             state_q;
    logic [VW-1:0]      coords_q;
    logic [CNT_W-1:0]   nverts_q, nedges_q, k_q, e_q;
    logic [COORD_W-1:0] min_x_q, min_y_q;
    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic               reset_buff_q, draw_en_q, seq_done_q, error_q, busy_q;

    logic [COORD_W-1:0] min_x_d, min_y_d;
    logic [COORD_W-1:0] x0_d, y0_d, x1_d, y1_d;
    logic [CNT_W-1:0]   dst_idx;
    logic [COORD_W-1:0] kx, ky, sx, sy, dx, dy;

    // Mux one coordinate out of the latched vertex array.
    function automatic logic [COORD_W-1:0] vsel(input logic [VW-1:0]    c,
                                                input logic [CNT_W-1:0] idx,
                                                input bit               is_y);
        vsel = '0;
        for (int k = 0; k < MAX_VERTS; k++)
            if (idx == CNT_W'(k))
                vsel = is_y ? c[2*COORD_W*k+COORD_W +: COORD_W]
                            : c[2*COORD_W*k +: COORD_W];
    endfunction

    always_comb begin
        kx = vsel(coords_q, k_q, 1'b0);
        ky = vsel(coords_q, k_q, 1'b1);
        min_x_d = (kx < min_x_q) ? kx : min_x_q;
        min_y_d = (ky < min_y_q) ? ky : min_y_q;

        // Edge e goes e -> e+1, except the closing edge which wraps to 0.
        dst_idx = (e_q == nverts_q - CNT_W'(1)) ? '0 : e_q + CNT_W'(1);
        sx = vsel(coords_q, e_q, 1'b0);
        sy = vsel(coords_q, e_q, 1'b1);
        dx = vsel(coords_q, dst_idx, 1'b0);
        dy = vsel(coords_q, dst_idx, 1'b1);
        x0_d = sx - min_x_q;
        y0_d = sy - min_y_q;
        x1_d = dx - min_x_q;
        y1_d = dy - min_y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            coords_q     <= '0;
            nverts_q     <= '0;
            nedges_q     <= '0;
            k_q          <= '0;
            e_q          <= '0;
            min_x_q      <= '0;
            min_y_q      <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            reset_buff_q <= 1'b0;
            draw_en_q    <= 1'b0;
            seq_done_q   <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            reset_buff_q <= 1'b0;
            seq_done_q   <= 1'b0;
            error_q      <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    coords_q <= coordinates;
                    nverts_q <= vert_count;
                    // Two-vertex closed shape would duplicate its only edge.
                    nedges_q <= (closed && vert_count != CNT_W'(2))
                                ? vert_count : vert_count - CNT_W'(1);
                    k_q      <= '0;
                    e_q      <= '0;
                    min_x_q  <= '1;
                    min_y_q  <= '1;
                    busy_q   <= 1'b1;
                    if (vert_count < CNT_W'(2) || vert_count > CNT_W'(MAX_VERTS)) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else begin
                        state_q <= S_MIN;
                    end
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_MIN: begin
                    min_x_q <= min_x_d;
                    min_y_q <= min_y_d;
                    k_q     <= k_q + CNT_W'(1);
                    if (k_q == nverts_q - CNT_W'(1)) begin
                        state_q      <= S_CLEAR;
                        reset_buff_q <= 1'b1;
                    end
                end
                S_CLEAR, S_GAP: begin
                    state_q   <= S_DRAW;
                    draw_en_q <= 1'b1;
                    x0_q      <= x0_d;
                    y0_q      <= y0_d;
                    x1_q      <= x1_d;
                    y1_q      <= y1_d;
                end
                S_DRAW: if (draw_done) begin
                    draw_en_q <= 1'b0;
                    x0_q      <= '0;
                    y0_q      <= '0;
                    x1_q      <= '0;
                    y1_q      <= '0;
                    if (e_q == nedges_q - CNT_W'(1)) begin
                        state_q    <= S_DONE;
                        seq_done_q <= 1'b1;
                    end else begin
                        state_q <= S_GAP;
                        e_q     <= e_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign reset_buff = reset_buff_q;
    assign x0         = x0_q;
    assign y0         = y0_q;
    assign x1         = x1_q;
    assign y1         = y1_q;
    assign draw_en    = draw_en_q;
    assign seq_done   = seq_done_q;
    assign error      = error_q;
    assign busy       = busy_q;
endmodule
